chart_recorder: RTL

Records player button taps into a chart memory, quantized to beat slots, producing the same two-lane, 2-bit-per-lane note words that the chart ROM supplies to playback. It sits beside the playback path, driven by the same debounced click inputs and the beat-slot strobe derived from the divided clock. Its write port feeds a 4096-entry chart RAM that playback later reads in place of the ROM.

---
 rtl/chart_recorder_if.sv | 27 ++
 rtl/chart_recorder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/chart_recorder_if.sv
// Chart recorder bus: control strobes and click levels in, chart RAM write port and status out.
interface chart_recorder_if #(
    parameter int ADDR_W = 12
);
    logic              step;
    logic              rec_start;
    logic              rec_stop;
    logic              clickup;
    logic              clickdown;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        wr_noteup;
    logic [1:0]        wr_notedown;
    logic              recording;
    logic              done;
    logic [ADDR_W-1:0] note_count;

    modport master (
        input  step, rec_start, rec_stop, clickup, clickdown,
        output wr_en, wr_addr, wr_noteup, wr_notedown, recording, done, note_count
    );

    modport slave (
        output step, rec_start, rec_stop, clickup, clickdown,
        input  wr_en, wr_addr, wr_noteup, wr_notedown, recording, done, note_count
    );
endinterface

// File: rtl/chart_recorder.sv
// Quantizes two-lane button taps to beat slots and writes note words into the chart RAM.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for rec_start
// ST_ARMED | waiting for the first step, which aligns slot 0
// ST_REC   | collecting clicks per slot, one word written per step
// ST_FLUSH | end marker emitted (mark_q set) or still owed (mark_q clear)
// ST_DONE  | chart complete, address and note count held
module chart_recorder #(
    parameter int ADDR_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    chart_recorder_if.master bus
);
    typedef enum logic [2:0] {ST_IDLE, ST_ARMED, ST_REC, ST_FLUSH, ST_DONE} state_t;

    localparam logic [1:0]        CODE_NONE = 2'b00;
    localparam logic [1:0]        CODE_TAP  = 2'b01;
    localparam logic [1:0]        CODE_HOLD = 2'b10;
    localparam logic [1:0]        CODE_END  = 2'b11;
    localparam logic [ADDR_W-1:0] LAST_SLOT = {{(ADDR_W-1){1'b1}}, 1'b0};
    localparam logic [ADDR_W-1:0] CNT_MAX   = '1;

    state_t            state_q;
    logic              prev_up_q, prev_dn_q;
    logic              seen_up_q, seen_dn_q;
    logic              rel_up_q, rel_dn_q;
    logic [1:0]        last_up_q, last_dn_q;
    logic              inc_q;
    logic              mark_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [1:0]        noteup_q, notedown_q;
    logic              recording_q, done_q;
    logic [ADDR_W-1:0] note_count_q;

    logic       rise_up_d, rise_dn_d;
    logic [1:0] code_up_d, code_dn_d;
    logic       tap_d;

    always_comb begin
        rise_up_d = bus.clickup & ~prev_up_q;
        rise_dn_d = bus.clickdown & ~prev_dn_q;
        code_up_d = CODE_NONE;
        code_dn_d = CODE_NONE;
        if (seen_up_q || rise_up_d)
            code_up_d = CODE_TAP;
        else if (!rel_up_q && bus.clickup && (last_up_q == CODE_TAP || last_up_q == CODE_HOLD))
            code_up_d = CODE_HOLD;
        if (seen_dn_q || rise_dn_d)
            code_dn_d = CODE_TAP;
        else if (!rel_dn_q && bus.clickdown && (last_dn_q == CODE_TAP || last_dn_q == CODE_HOLD))
            code_dn_d = CODE_HOLD;
        tap_d = (code_up_d == CODE_TAP) || (code_dn_d == CODE_TAP);
    end

    // The address advances the cycle after a slot write, so wr_addr shows the written address while wr_en is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prev_up_q    <= 1'b0;
            prev_dn_q    <= 1'b0;
            seen_up_q    <= 1'b0;
            seen_dn_q    <= 1'b0;
            rel_up_q     <= 1'b0;
            rel_dn_q     <= 1'b0;
            last_up_q    <= CODE_NONE;
            last_dn_q    <= CODE_NONE;
            inc_q        <= 1'b0;
            mark_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            noteup_q     <= CODE_NONE;
            notedown_q   <= CODE_NONE;
            recording_q  <= 1'b0;
            done_q       <= 1'b0;
            note_count_q <= '0;
        end else begin
            prev_up_q <= bus.clickup;
            prev_dn_q <= bus.clickdown;
            wr_en_q   <= 1'b0;
            inc_q     <= 1'b0;
            if (inc_q)
                wr_addr_q <= wr_addr_q + 1'b1;

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.rec_start) begin
                        state_q      <= ST_ARMED;
                        wr_addr_q    <= '0;
                        note_count_q <= '0;
                        seen_up_q    <= 1'b0;
                        seen_dn_q    <= 1'b0;
                        rel_up_q     <= 1'b0;
                        rel_dn_q     <= 1'b0;
                        last_up_q    <= CODE_NONE;
                        last_dn_q    <= CODE_NONE;
                        recording_q  <= 1'b1;
                        done_q       <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (bus.rec_stop) begin
                        state_q     <= ST_IDLE;
                        recording_q <= 1'b0;
                    end else if (bus.step) begin
                        state_q   <= ST_REC;
                        seen_up_q <= 1'b0;
                        seen_dn_q <= 1'b0;
                        rel_up_q  <= 1'b0;
                        rel_dn_q  <= 1'b0;
                    end
                end
                ST_REC: begin
                    if (bus.step) begin
                        wr_en_q    <= 1'b1;
                        inc_q      <= 1'b1;
                        noteup_q   <= code_up_d;
                        notedown_q <= code_dn_d;
                        last_up_q  <= code_up_d;
                        last_dn_q  <= code_dn_d;
                        seen_up_q  <= 1'b0;
                        seen_dn_q  <= 1'b0;
                        rel_up_q   <= 1'b0;
                        rel_dn_q   <= 1'b0;
                        if (tap_d && note_count_q != CNT_MAX)
                            note_count_q <= note_count_q + 1'b1;
                        if (bus.rec_stop || wr_addr_q == LAST_SLOT) begin
                            state_q     <= ST_FLUSH;
                            recording_q <= 1'b0;
                            mark_q      <= 1'b0;
                        end
                    end else if (bus.rec_stop) begin
                        wr_en_q     <= 1'b1;
                        noteup_q    <= CODE_END;
                        notedown_q  <= CODE_END;
                        state_q     <= ST_FLUSH;
                        recording_q <= 1'b0;
                        mark_q      <= 1'b1;
                    end else begin
                        seen_up_q <= seen_up_q | rise_up_d;
                        seen_dn_q <= seen_dn_q | rise_dn_d;
                        rel_up_q  <= rel_up_q | ~bus.clickup;
                        rel_dn_q  <= rel_dn_q | ~bus.clickdown;
                    end
                end
                ST_FLUSH: begin
                    if (!mark_q) begin
                        wr_en_q    <= 1'b1;
                        noteup_q   <= CODE_END;
                        notedown_q <= CODE_END;
                        mark_q     <= 1'b1;
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_noteup   = noteup_q;
    assign bus.wr_notedown = notedown_q;
    assign bus.recording   = recording_q;
    assign bus.done        = done_q;
    assign bus.note_count  = note_count_q;
endmodule
